// File: rtl/pc_branch_unit.sv
// ---------------------------------------------------------------------------
// pc_branch_unit
//   Owns the core PC and sequences instruction fetch: FETCH issues a word
//   request to instruction memory, the returned instruction is held for
//   decode, and the EXEC cycle picks the next PC from the decoded flags and
//   the ALU branch decision / JALR target.
//
//   Optional feature macro: PC_BRANCH_STATS_EN
//     When defined, adds saturating taken-branch, untaken-branch and
//     executed-instruction counters with their output ports.
//     When undefined, those ports and counters do not exist.
// ---------------------------------------------------------------------------
module pc_branch_unit #(
   parameter int PC_W     = 10,  // PC / imem word-address width (< 32)
   parameter int OFFSET_W = 8    // signed branch offset width, in words (<= PC_W)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start_i,
   input  logic [PC_W-1:0]     start_pc_i,
   output logic                imem_req_o,
   output logic [PC_W-1:0]     imem_addr_o,
   input  logic                imem_valid_i,
   input  logic [31:0]         imem_data_i,
   output logic [31:0]         instr_o,
   output logic                instr_valid_o,
   input  logic                stall_i,
   input  logic                is_branch_i,
   input  logic                is_jalr_i,
   input  logic                is_done_i,
   input  logic [OFFSET_W-1:0] br_offset_i,
   input  logic                jump_now_i,
   input  logic [31:0]         alu_result_i,
   output logic [PC_W-1:0]     pc_o,
   output logic [PC_W-1:0]     pc_plus1_o,
   output logic                halted_o
`ifdef PC_BRANCH_STATS_EN
   ,
   output logic [15:0]         br_taken_o,
   output logic [15:0]         br_nottaken_o,
   output logic [31:0]         instr_count_o
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [31:0]     instr_q, instr_d;

   // EXEC cycle that commits (not frozen by a stall)
   logic            exec_fire;
   // Branch decision gated by is_branch_i so an undriven jump_now_i never
   // reaches the PC mux on non-branch instructions
   logic            br_taken;
   logic [PC_W-1:0] br_offset_sext;
   logic [PC_W-1:0] pc_inc;
   // Only the low PC_W bits of the ALU result form a JALR target
   logic            alu_hi_unused;

   always_comb exec_fire      = (state_q == ST_EXEC) && !stall_i;
   always_comb br_taken       = is_branch_i & jump_now_i;
   always_comb br_offset_sext = {{(PC_W-OFFSET_W){br_offset_i[OFFSET_W-1]}}, br_offset_i};
   always_comb pc_inc         = pc_q + PC_W'(1);
   always_comb alu_hi_unused  = ^alu_result_i[31:PC_W];

   // State register; async reset drops a pending fetch request immediately
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // pre-edge values regardless of statement order.
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: every combinational output gets a default first; a path that
      // leaves it unassigned would otherwise infer a latch.
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_i)      state_d = ST_FETCH;
         ST_FETCH: if (imem_valid_i) state_d = ST_EXEC;
         ST_EXEC:  if (!stall_i)     state_d = is_done_i ? ST_HALT : ST_FETCH;
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      imem_req_o    = (state_q == ST_FETCH);
      instr_valid_o = (state_q == ST_EXEC);
      halted_o      = (state_q == ST_HALT);
      imem_addr_o   = pc_q;
      pc_o          = pc_q;
      pc_plus1_o    = pc_inc;
      instr_o       = instr_q;
   end

   // Next PC and instruction hold; decode priority done > jalr > branch
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      if ((state_q == ST_IDLE) && start_i) begin
         pc_d = start_pc_i;
      end
      if ((state_q == ST_FETCH) && imem_valid_i) begin
         instr_d = imem_data_i;
      end
      if (exec_fire) begin
         if (is_done_i) begin
            pc_d = pc_q;
         end else if (is_jalr_i) begin
            pc_d = alu_result_i[PC_W-1:0];
         end else if (br_taken) begin
            pc_d = pc_q + br_offset_sext;
         end else begin
            pc_d = pc_inc;
         end
      end
   end

   // PC and instruction registers
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: these are plain registers, not a memory array, so they take
      // the reset like any other state.
      if (!reset_n) begin
         pc_q    <= '0;
         instr_q <= '0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

`ifdef PC_BRANCH_STATS_EN
   logic [15:0] br_taken_q, br_taken_d;
   logic [15:0] br_nottaken_q, br_nottaken_d;
   logic [31:0] instr_count_q, instr_count_d;
   logic        kind_branch;

   // A committing EXEC counts as a branch only when no higher-priority flag wins
   always_comb kind_branch = exec_fire && !is_done_i && !is_jalr_i && is_branch_i;

   // Saturating statistics counters
   always_comb begin
      br_taken_d    = br_taken_q;
      br_nottaken_d = br_nottaken_q;
      instr_count_d = instr_count_q;
      if (kind_branch && jump_now_i && (br_taken_q != '1)) begin
         br_taken_d = br_taken_q + 16'd1;
      end
      if (kind_branch && !jump_now_i && (br_nottaken_q != '1)) begin
         br_nottaken_d = br_nottaken_q + 16'd1;
      end
      if (exec_fire && (instr_count_q != '1)) begin
         instr_count_d = instr_count_q + 32'd1;
      end
   end

   // Counter registers, cleared only by reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         br_taken_q    <= '0;
         br_nottaken_q <= '0;
         instr_count_q <= '0;
      end else begin
         br_taken_q    <= br_taken_d;
         br_nottaken_q <= br_nottaken_d;
         instr_count_q <= instr_count_d;
      end
   end

   always_comb begin
      br_taken_o    = br_taken_q;
      br_nottaken_o = br_nottaken_q;
      instr_count_o = instr_count_q;
   end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_branch_unit
//   Directed bench: a table of instructions (fetch latency, decode flags,
//   expected PC and next PC) walked through the fetch/execute loop, followed
//   by hand-written HALT and reset-mid-fetch sequences.
//   Build with +define+PC_BRANCH_STATS_EN to also check the counters.
// ---------------------------------------------------------------------------
module tb_pc_branch_unit;

   localparam int PC_W     = 10;
   localparam int OFFSET_W = 8;
   localparam int N_VEC    = 16;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                start_i;
   logic [PC_W-1:0]     start_pc_i;
   logic                imem_req_o;
   logic [PC_W-1:0]     imem_addr_o;
   logic                imem_valid_i;
   logic [31:0]         imem_data_i;
   logic [31:0]         instr_o;
   logic                instr_valid_o;
   logic                stall_i;
   logic                is_branch_i;
   logic                is_jalr_i;
   logic                is_done_i;
   logic [OFFSET_W-1:0] br_offset_i;
   logic                jump_now_i;
   logic [31:0]         alu_result_i;
   logic [PC_W-1:0]     pc_o;
   logic [PC_W-1:0]     pc_plus1_o;
   logic                halted_o;
`ifdef PC_BRANCH_STATS_EN
   logic [15:0]         br_taken_o;
   logic [15:0]         br_nottaken_o;
   logic [31:0]         instr_count_o;
`endif

   pc_branch_unit #(.PC_W(PC_W), .OFFSET_W(OFFSET_W)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start_i       (start_i),
      .start_pc_i    (start_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_valid_i  (imem_valid_i),
      .imem_data_i   (imem_data_i),
      .instr_o       (instr_o),
      .instr_valid_o (instr_valid_o),
      .stall_i       (stall_i),
      .is_branch_i   (is_branch_i),
      .is_jalr_i     (is_jalr_i),
      .is_done_i     (is_done_i),
      .br_offset_i   (br_offset_i),
      .jump_now_i    (jump_now_i),
      .alu_result_i  (alu_result_i),
      .pc_o          (pc_o),
      .pc_plus1_o    (pc_plus1_o),
      .halted_o      (halted_o)
`ifdef PC_BRANCH_STATS_EN
      ,
      .br_taken_o    (br_taken_o),
      .br_nottaken_o (br_nottaken_o),
      .instr_count_o (instr_count_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PC_W-1:0]     pc;     // expected fetch address / EXEC pc
      int                  lat;    // imem response latency in cycles (>=1)
      logic                br;
      logic                jalr;
      logic                done;
      logic [OFFSET_W-1:0] off;
      logic                jn;
      logic [31:0]         alu;
      int                  stall;  // EXEC stall cycles before commit
      logic [PC_W-1:0]     nxt;    // expected next fetch address (or held pc on DONE)
   } vec_t;

   vec_t vecs [N_VEC];

   int n_cmp = 0;
   int n_err = 0;
   int exp_taken = 0;
   int exp_nottaken = 0;
   int exp_instr = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_decode();
      is_branch_i  = 1'b0;
      is_jalr_i    = 1'b0;
      is_done_i    = 1'b0;
      br_offset_i  = '0;
      jump_now_i   = 1'b0;
      alu_result_i = '0;
      stall_i      = 1'b0;
   endtask

   // One instruction: fetch with the given latency, then execute
   task automatic run_vec(input int idx);
      vec_t            v;
      logic [31:0]     data;
      logic [PC_W-1:0] p1;
      int              waited;
      v      = vecs[idx];
      data   = 32'hC0DE_0000 | 32'(idx);
      p1     = v.pc + 10'd1;
      waited = 0;
      while (!imem_req_o && waited < 20) begin
         tick();
         waited++;
      end
      if (!imem_req_o) begin
         check($sformatf("v%0d req_timeout", idx), {31'd0, imem_req_o}, 32'd1);
         return;
      end
      check($sformatf("v%0d fetch_addr", idx), 32'(imem_addr_o), 32'(v.pc));
      // Spurious start_i while fetching must be ignored
      start_i    = 1'b1;
      start_pc_i = 10'h2AA;
      for (int i = 0; i < v.lat; i++) begin
         tick();
         check($sformatf("v%0d req_held", idx), {31'd0, imem_req_o}, 32'd1);
         check($sformatf("v%0d addr_held", idx), 32'(imem_addr_o), 32'(v.pc));
      end
      imem_valid_i = 1'b1;
      imem_data_i  = data;
      tick();
      imem_valid_i = 1'b0;
      imem_data_i  = '0;
      start_i      = 1'b0;
      check($sformatf("v%0d instr_valid", idx), {31'd0, instr_valid_o}, 32'd1);
      check($sformatf("v%0d req_drop", idx), {31'd0, imem_req_o}, 32'd0);
      check($sformatf("v%0d pc", idx), 32'(pc_o), 32'(v.pc));
      check($sformatf("v%0d pc_plus1", idx), 32'(pc_plus1_o), 32'(p1));
      check($sformatf("v%0d instr", idx), instr_o, data);
      is_branch_i  = v.br;
      is_jalr_i    = v.jalr;
      is_done_i    = v.done;
      br_offset_i  = v.off;
      jump_now_i   = v.jn;
      alu_result_i = v.alu;
      if (v.stall > 0) begin
         stall_i      = 1'b1;
         // imem_valid_i outside FETCH must not disturb the held instruction
         imem_valid_i = 1'b1;
         imem_data_i  = ~data;
         for (int i = 0; i < v.stall; i++) begin
            tick();
            check($sformatf("v%0d stall_valid", idx), {31'd0, instr_valid_o}, 32'd1);
            check($sformatf("v%0d stall_pc", idx), 32'(pc_o), 32'(v.pc));
            check($sformatf("v%0d stall_instr", idx), instr_o, data);
         end
         stall_i      = 1'b0;
         imem_valid_i = 1'b0;
         imem_data_i  = '0;
      end
      tick();
      clear_decode();
      exp_instr++;
      if (v.br && !v.jalr && !v.done) begin
         if (v.jn) exp_taken++;
         else      exp_nottaken++;
      end
      if (v.done) begin
         check($sformatf("v%0d halted", idx), {31'd0, halted_o}, 32'd1);
         check($sformatf("v%0d halt_pc", idx), 32'(pc_o), 32'(v.nxt));
      end else begin
         check($sformatf("v%0d next_req", idx), {31'd0, imem_req_o}, 32'd1);
         check($sformatf("v%0d next_addr", idx), 32'(imem_addr_o), 32'(v.nxt));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //          pc      lat br   jalr done off    jn    alu            stall nxt
      vecs[0]  = '{10'h010, 1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0000_0000, 0, 10'h011};
      vecs[1]  = '{10'h011, 3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0000_0000, 0, 10'h012};
      vecs[2]  = '{10'h012, 3, 1'b1, 1'b0, 1'b0, 8'hFE, 1'b1, 32'h0000_0000, 0, 10'h010};
      vecs[3]  = '{10'h010, 3, 1'b0, 1'b0, 1'b0, 8'h00, 1'bx, 32'h0000_0000, 0, 10'h011};
      vecs[4]  = '{10'h011, 2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0000_0000, 0, 10'h012};
      vecs[5]  = '{10'h012, 1, 1'b1, 1'b0, 1'b0, 8'hFE, 1'b0, 32'h0000_0000, 0, 10'h013};
      vecs[6]  = '{10'h013, 1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0000_03FF, 0, 10'h3FF};
      vecs[7]  = '{10'h3FF, 1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 32'h0000_0200, 0, 10'h200};
      vecs[8]  = '{10'h200, 1, 1'b1, 1'b0, 1'b0, 8'h05, 1'b1, 32'h0000_0000, 4, 10'h205};
      vecs[9]  = '{10'h205, 1, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 32'h0000_0000, 0, 10'h185};
      vecs[10] = '{10'h185, 1, 1'b1, 1'b1, 1'b0, 8'h03, 1'b1, 32'h0000_0123, 0, 10'h123};
      vecs[11] = '{10'h123, 1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'hFFFF_FFFE, 0, 10'h3FE};
      vecs[12] = '{10'h3FE, 1, 1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 32'h0000_0000, 0, 10'h001};
      vecs[13] = '{10'h001, 1, 1'b1, 1'b0, 1'b0, 8'hFE, 1'b1, 32'h0000_0000, 2, 10'h3FF};
      vecs[14] = '{10'h3FF, 1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0000_0000, 0, 10'h000};
      vecs[15] = '{10'h000, 2, 1'b1, 1'b1, 1'b1, 8'h05, 1'b1, 32'h0000_0123, 0, 10'h000};

      reset_n      = 1'b0;
      start_i      = 1'b0;
      start_pc_i   = '0;
      imem_valid_i = 1'b0;
      imem_data_i  = '0;
      clear_decode();

      // Reset held: start_i must not leave IDLE
      start_i    = 1'b1;
      start_pc_i = 10'h155;
      repeat (3) tick();
      start_i = 1'b0;
      check("rst_req", {31'd0, imem_req_o}, 32'd0);
      check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
      check("rst_halted", {31'd0, halted_o}, 32'd0);
      check("rst_pc", 32'(pc_o), 32'd0);
      check("rst_pc_plus1", 32'(pc_plus1_o), 32'd1);
      check("rst_instr", instr_o, 32'd0);
`ifdef PC_BRANCH_STATS_EN
      check("rst_br_taken", 32'(br_taken_o), 32'd0);
      check("rst_br_nottaken", 32'(br_nottaken_o), 32'd0);
      check("rst_instr_count", instr_count_o, 32'd0);
`endif
      reset_n = 1'b1;
      tick();
      check("idle_no_req", {31'd0, imem_req_o}, 32'd0);

      // Start pulse
      start_i    = 1'b1;
      start_pc_i = 10'h010;
      tick();
      start_i    = 1'b0;
      start_pc_i = '0;

      for (int i = 0; i < N_VEC; i++) run_vec(i);

      // HALT: start_i and imem_valid_i ignored
      start_i      = 1'b1;
      start_pc_i   = 10'h077;
      imem_valid_i = 1'b1;
      imem_data_i  = 32'hDEAD_BEEF;
      repeat (3) tick();
      start_i      = 1'b0;
      imem_valid_i = 1'b0;
      check("halt_stays", {31'd0, halted_o}, 32'd1);
      check("halt_no_req", {31'd0, imem_req_o}, 32'd0);
      check("halt_no_valid", {31'd0, instr_valid_o}, 32'd0);
      check("halt_pc_hold", 32'(pc_o), 32'h000);
      check("halt_instr_hold", instr_o, 32'hC0DE_000F);
`ifdef PC_BRANCH_STATS_EN
      check("stat_br_taken", 32'(br_taken_o), 32'(exp_taken));
      check("stat_br_nottaken", 32'(br_nottaken_o), 32'(exp_nottaken));
      check("stat_instr_count", instr_count_o, 32'(exp_instr));
`endif

      // Reset leaves HALT
      reset_n = 1'b0;
      #1;
      check("rst2_halted", {31'd0, halted_o}, 32'd0);
      check("rst2_instr", instr_o, 32'd0);
      tick();
      reset_n    = 1'b1;
      start_i    = 1'b1;
      start_pc_i = 10'h050;
      tick();
      start_i = 1'b0;
      check("restart_req", {31'd0, imem_req_o}, 32'd1);
      check("restart_addr", 32'(imem_addr_o), 32'h050);
      tick();
      // Mid-cycle reset while fetching drops the request at once
      #2;
      reset_n = 1'b0;
      #1;
      check("midfetch_req_drop", {31'd0, imem_req_o}, 32'd0);
      check("midfetch_pc", 32'(pc_o), 32'd0);
      tick();
      reset_n      = 1'b1;
      imem_valid_i = 1'b1;
      imem_data_i  = 32'h1234_5678;
      tick();
      imem_valid_i = 1'b0;
      imem_data_i  = '0;
      check("late_valid_no_exec", {31'd0, instr_valid_o}, 32'd0);
      check("late_valid_instr", instr_o, 32'd0);
      check("late_valid_no_req", {31'd0, imem_req_o}, 32'd0);
`ifdef PC_BRANCH_STATS_EN
      check("rst2_instr_count", instr_count_o, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
